// File: rtl/pic_prog_pkg.sv
// Shared PIC parameter set plus the loader's command opcodes and FSM states.
package pic_prog_pkg;

    localparam int L2_PIC_INSTR_MEM_DEPTH = 9;
    localparam int PIC_INSTR_WIDTH        = 12;

    localparam logic [7:0] CMD_START = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_ADDR  = 8'h41;
    localparam logic [7:0] CMD_END   = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_W_HI,
        ST_W_LO,
        ST_WRITE,
        ST_A_HI,
        ST_A_LO,
        ST_RELEASE
    } prog_state_e;

endpackage

// File: rtl/pic_prog_timer.sv
// Loadable down-counter shared by the operand timeout and the CPU release hold.
// Loading value V makes expired_o rise V cycles later (V=0 expires at once).
module pic_prog_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/pic_prog_loader.sv
// Byte-stream programming controller: holds the PIC CPU in reset, writes the
// instruction memory from a host command stream, then releases the CPU.
module pic_prog_loader
    import pic_prog_pkg::*;
#(
    parameter int RELEASE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              program_mode,
    output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] waddr,
    output logic [PIC_INSTR_WIDTH-1:0]        wdata,
    output logic                              we,
    output logic                              cpu_hold,
    output logic                              err,
    output logic [L2_PIC_INSTR_MEM_DEPTH:0]   words_written
);

    localparam int AW  = L2_PIC_INSTR_MEM_DEPTH;
    localparam int DW  = PIC_INSTR_WIDTH;
    // Wide enough for both TIMEOUT_CYCLES-1 and RELEASE_CYCLES-1 (<=254).
    localparam int TW  = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] REL_LOAD = TW'(RELEASE_CYCLES - 1);

    prog_state_e          state_q, state_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-9:0]        op_hi_q, op_hi_d;
    logic [AW-9:0]        addr_hi_q, addr_hi_d;
    logic                 err_q, err_d;
    logic [AW:0]          words_q, words_d;
    logic                 pm_q, pm_d;
    logic                 hold_q, hold_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic                 accept;
    logic                 tmr_expired;
    logic [TW-1:0]        tmr_value;

    assign accept = in_valid & ready_q;

    // Every accepted byte restarts the timer; END loads the release hold instead.
    pic_prog_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    // Next-state, operand assembly and counter updates.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        op_hi_d   = op_hi_q;
        addr_hi_d = addr_hi_q;
        err_d     = err_q;
        words_d   = words_q;
        pm_d      = pm_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_data == CMD_START) begin
                        state_d = ST_PROG;
                        hold_d  = 1'b1;
                        pm_d    = 1'b1;
                        waddr_d = '0;
                        err_d   = 1'b0;
                        words_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PROG: begin
                if (accept) begin
                    case (in_data)
                        CMD_WRITE: state_d = ST_W_HI;
                        CMD_ADDR:  state_d = ST_A_HI;
                        CMD_END: begin
                            state_d = ST_RELEASE;
                            pm_d    = 1'b0;
                        end
                        CMD_START: begin
                            waddr_d = '0;
                            err_d   = 1'b0;
                            words_d = '0;
                        end
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            ST_W_HI: begin
                if (accept) begin
                    op_hi_d = in_data[DW-9:0];
                    if (in_data[7:DW-8] != '0) err_d = 1'b1;
                    state_d = ST_W_LO;
                end else if (tmr_expired) begin
                    state_d = ST_PROG;
                    err_d   = 1'b1;
                end
            end
            ST_W_LO: begin
                if (accept) begin
                    wdata_d = {op_hi_q, in_data};
                    state_d = ST_WRITE;
                end else if (tmr_expired) begin
                    state_d = ST_PROG;
                    err_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                waddr_d = waddr_q + AW'(1);
                if (waddr_q == '1) err_d = 1'b1;
                if (words_q != '1) words_d = words_q + (AW+1)'(1);
                state_d = ST_PROG;
            end
            ST_A_HI: begin
                if (accept) begin
                    addr_hi_d = in_data[AW-9:0];
                    if (in_data[7:AW-8] != '0) err_d = 1'b1;
                    state_d = ST_A_LO;
                end else if (tmr_expired) begin
                    state_d = ST_PROG;
                    err_d   = 1'b1;
                end
            end
            ST_A_LO: begin
                if (accept) begin
                    waddr_d = {addr_hi_q, in_data};
                    state_d = ST_PROG;
                end else if (tmr_expired) begin
                    state_d = ST_PROG;
                    err_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (tmr_expired) begin
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tmr_value = (state_d == ST_RELEASE) ? REL_LOAD : TMO_LOAD;
        ready_d   = !((state_d == ST_WRITE) || (state_d == ST_RELEASE));
        we_d      = (state_d == ST_WRITE);
    end

    // State and registered outputs; reset aborts any in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            op_hi_q   <= '0;
            addr_hi_q <= '0;
            err_q     <= 1'b0;
            words_q   <= '0;
            pm_q      <= 1'b0;
            hold_q    <= 1'b0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            op_hi_q   <= op_hi_d;
            addr_hi_q <= addr_hi_d;
            err_q     <= err_d;
            words_q   <= words_d;
            pm_q      <= pm_d;
            hold_q    <= hold_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
        end
    end

    assign in_ready      = ready_q;
    assign program_mode  = pm_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign we            = we_q;
    assign cpu_hold      = hold_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
// Directed bench: expected writes go into a scoreboard queue, a monitor pops
// and compares them whenever we is seen high.
module tb_pic_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        program_mode;
    logic [8:0]  waddr;
    logic [11:0] wdata;
    logic        we;
    logic        cpu_hold;
    logic        err;
    logic [9:0]  words_written;

    typedef struct {
        logic [8:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  we_cyc[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  lowcnt = 0;
    bit  cnt_en = 1'b0;

    pic_prog_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .program_mode  (program_mode),
        .waddr         (waddr),
        .wdata         (wdata),
        .we            (we),
        .cpu_hold      (cpu_hold),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (cnt_en && !in_ready) lowcnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && we === 1'b1) begin
            wr_t e;
            we_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== e.a || wdata !== e.d) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             waddr, wdata, e.a, e.d);
                end else begin
                    $display("ok   write addr 0x%0h data 0x%0h", waddr, wdata);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: got %0b expected 0", in_ready);
            end
        end
    end

    task automatic push_wr(input logic [8:0] a, input logic [11:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Present one byte and return #1 after the edge that accepts it.
    task automatic send(input logic [7:0] b, input bit keep = 1'b0);
        int g;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait: got in_ready 0 for 50 cycles expected 1 (byte 0x%0h)", b);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_program_mode"}, 32'(program_mode), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---- reset state
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // ---- test 1: single write then END / release timing
        send(8'hA5);
        chk("t1_cpu_hold_on", 32'(cpu_hold), 32'd1);
        chk("t1_pm_on", 32'(program_mode), 32'd1);
        send(8'h57);
        send(8'h0A);
        push_wr(9'h000, 12'hABC);
        send(8'hBC);
        chk("t1_we_now", 32'(we), 32'd1);
        chk("t1_wdata", 32'(wdata), 32'hABC);
        send(8'h5A);
        chk("t1_pm_off", 32'(program_mode), 32'd0);
        chk("t1_hold_still", 32'(cpu_hold), 32'd1);
        chk("t1_ready_release", 32'(in_ready), 32'd0);
        chk("t1_words", 32'(words_written), 32'd1);
        n = 0;
        while (cpu_hold && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t1_release_edges", 32'(n), 32'd16);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_ready_idle", 32'(in_ready), 32'd1);

        // ---- test 2: address load and wrap
        do_reset();
        send(8'hA5); send(8'h41); send(8'h01); send(8'hFE);
        chk("t2_waddr_load", 32'(waddr), 32'h1FE);
        push_wr(9'h1FE, 12'h001);
        send(8'h57); send(8'h00); send(8'h01);
        @(posedge clk); #1;
        chk("t2_waddr_1ff", 32'(waddr), 32'h1FF);
        chk("t2_err_before_wrap", 32'(err), 32'd0);
        push_wr(9'h1FF, 12'h002);
        send(8'h57); send(8'h00); send(8'h02);
        @(posedge clk); #1;
        chk("t2_waddr_wrap", 32'(waddr), 32'h000);
        chk("t2_err_wrap", 32'(err), 32'd1);
        chk("t2_words", 32'(words_written), 32'd2);

        // ---- test 3: unknown bytes
        do_reset();
        send(8'h33);
        chk("t3_err_idle", 32'(err), 32'd1);
        chk("t3_pm_idle", 32'(program_mode), 32'd0);
        send(8'hA5);
        chk("t3_err_cleared", 32'(err), 32'd0);
        send(8'h33);
        chk("t3_err_prog", 32'(err), 32'd1);
        chk("t3_pm_prog", 32'(program_mode), 32'd1);
        send(8'h41); send(8'h00); send(8'h05);
        chk("t3_still_prog_addr", 32'(waddr), 32'h005);
        send(8'hA5);
        chk("t3_restart_err", 32'(err), 32'd0);
        chk("t3_restart_waddr", 32'(waddr), 32'h000);

        // ---- test 4: operand timeout
        do_reset();
        send(8'hA5); send(8'h57); send(8'h0F);
        repeat (1023) @(posedge clk);
        #1;
        chk("t4_err_before_timeout", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("t4_err_timeout", 32'(err), 32'd1);
        chk("t4_pm", 32'(program_mode), 32'd1);
        push_wr(9'h000, 12'h123);
        send(8'h57); send(8'h01); send(8'h23);
        @(posedge clk); #1;
        chk("t4_waddr_after", 32'(waddr), 32'h001);

        // ---- test 5: back-to-back stream with in_valid held high
        do_reset();
        we_cyc.delete();
        lowcnt = 0;
        cnt_en = 1'b1;
        push_wr(9'h000, 12'h011);
        push_wr(9'h001, 12'h022);
        send(8'hA5, 1'b1); send(8'h57, 1'b1); send(8'h00, 1'b1); send(8'h11, 1'b1);
        send(8'h57, 1'b1); send(8'h00, 1'b1); send(8'h22, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        cnt_en = 1'b0;
        chk("t5_ready_low_cycles", 32'(lowcnt), 32'd2);
        chk("t5_we_count", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2)
            chk("t5_we_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd4);
        chk("t5_waddr", 32'(waddr), 32'h002);
        chk("t5_words", 32'(words_written), 32'd2);

        // ---- test 6: reset asserted during W_LO
        do_reset();
        send(8'hA5); send(8'h57); send(8'h0A);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        in_data  = 8'hBC;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_we", 32'(we), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("t6_after");
        send(8'h41);
        chk("t6_idle_err", 32'(err), 32'd1);
        chk("t6_idle_pm", 32'(program_mode), 32'd0);

        repeat (2) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
